ebus_dev_responder: RTL and testbench

EBUS_DEV_RESPONDER -- requirements
Module: ebus_dev_responder

---
 rtl/ebus_dev_responder.sv | 156 +++++++++++++++
 tb/tb_ebus_dev_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_dev_responder.sv
// EBUS device responder: decodes CONO/CONI/DATAO/DATAI for one select code, xfer two clocks after demand.
// Side effects land once on the ACT->XFER edge; the output buffer holds BUSY until the core takes it.
module ebus_dev_responder #(
    parameter logic [6:0] DEV_NUM = 7'o0,
    parameter int         FUNC_W  = 3
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [6:0]        ebus_cs,
    input  logic [FUNC_W-1:0] ebus_func,
    input  logic              ebus_demand,
    input  logic [35:0]       ebus_data_in,
    output logic [35:0]       ebus_data_out,
    output logic              ebus_data_oe,
    output logic              ebus_xfer,
    output logic [6:0]        ebus_pi,
    output logic [35:0]       dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic [35:0]       dev_in_data,
    input  logic              dev_in_valid
);
    typedef enum logic [1:0] {IDLE, ACT, XFER, WAIT_DROP} state_t;

    localparam logic [FUNC_W-1:0] F_CONO  = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_CONI  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_DATAO = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_DATAI = FUNC_W'(3);

    state_t            state_q, state_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [6:0]        cs_q, cs_d;
    logic [35:0]       data_q, data_d;
    logic              err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic              valid_q, valid_d, need_low_q, need_low_d;
    logic [2:0]        pia_q, pia_d;
    logic [35:0]       obuf_q, obuf_d, ibuf_q, ibuf_d, rd_q, rd_d;
    logic              oe_q, oe_d, xfer_q, xfer_d;
    logic [6:0]        pi_q, pi_d;

    logic        sel, fire, is_cono, is_coni, is_datao, is_datai, hs;
    logic        done_set, done_clr, err_set, err_clr;
    logic [35:0] status;

    always_comb begin
        sel = ebus_demand && !need_low_q && (ebus_cs == DEV_NUM) && (ebus_func <= F_DATAI);
        state_d = state_q;
        func_d  = func_q;
        cs_d    = cs_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (sel) begin
                state_d = ACT;
                func_d  = ebus_func;
                cs_d    = ebus_cs;
                data_d  = ebus_data_in;
            end
            ACT:       state_d = ebus_demand ? XFER : WAIT_DROP;
            XFER:      if (!ebus_demand) state_d = WAIT_DROP;
            WAIT_DROP: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        need_low_d = need_low_q && ebus_demand;

        // The side effect fires on the ACT edge even if demand already fell.
        fire     = (state_q == ACT) && (cs_q == DEV_NUM);
        is_cono  = fire && (func_q == F_CONO);
        is_coni  = fire && (func_q == F_CONI);
        is_datao = fire && (func_q == F_DATAO);
        is_datai = fire && (func_q == F_DATAI);
        hs       = valid_q && dev_out_ready;

        // Bit 35-n here is EBUS bit n (EBUS numbers bit 0 as the MSB).
        done_set = (is_cono && data_q[3]) || hs || dev_in_valid;
        done_clr = (is_cono && data_q[4]) || is_datai;
        err_set  = (is_datao && busy_q) || (dev_in_valid && done_q);
        err_clr  = is_cono && data_q[5];
        done_d   = done_set || (done_q && !done_clr);
        err_d    = err_set || (err_q && !err_clr);
        pia_d    = is_cono ? data_q[2:0] : pia_q;

        busy_d  = busy_q;
        valid_d = valid_q;
        if (is_datao) begin
            busy_d  = 1'b1;
            valid_d = 1'b1;
        end else if (hs) begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end
        obuf_d = is_datao ? data_q : obuf_q;
        ibuf_d = dev_in_valid ? dev_in_data : ibuf_q;

        status = {30'd0, err_q, done_q, busy_q, pia_q};
        rd_d = '0;
        oe_d = 1'b0;
        if ((state_q == ACT) && ebus_demand && (is_coni || is_datai)) begin
            oe_d = 1'b1;
            rd_d = is_coni ? status : ibuf_q;
        end else if ((state_q == XFER) && ebus_demand) begin
            oe_d = oe_q;
            rd_d = rd_q;
        end
        xfer_d = (state_d == XFER);

        pi_d = '0;
        for (int l = 1; l <= 7; l++) begin
            pi_d[7-l] = (done_q || err_q) && (pia_q == 3'(l));
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            func_q     <= '0;
            cs_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            pia_q      <= '0;
            obuf_q     <= '0;
            ibuf_q     <= '0;
            rd_q       <= '0;
            oe_q       <= 1'b0;
            xfer_q     <= 1'b0;
            pi_q       <= '0;
            need_low_q <= ebus_demand;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            pia_q      <= pia_d;
            obuf_q     <= obuf_d;
            ibuf_q     <= ibuf_d;
            rd_q       <= rd_d;
            oe_q       <= oe_d;
            xfer_q     <= xfer_d;
            pi_q       <= pi_d;
            need_low_q <= need_low_d;
        end
    end

    assign ebus_data_out = rd_q;
    assign ebus_data_oe  = oe_q;
    assign ebus_xfer     = xfer_q;
    assign ebus_pi       = pi_q;
    assign dev_out_data  = obuf_q;
    assign dev_out_valid = valid_q;
endmodule

// File: tb/tb_ebus_dev_responder.sv
// Bench for ebus_dev_responder: directed scenarios then random transactions against an edge-level status model.
module tb_ebus_dev_responder;
    localparam logic [6:0] DEV = 7'o4;

    logic        clk = 1'b0;
    logic        RESET;
    logic [6:0]  ebus_cs;
    logic [2:0]  ebus_func;
    logic        ebus_demand;
    logic [35:0] ebus_data_in;
    logic [35:0] ebus_data_out;
    logic        ebus_data_oe, ebus_xfer;
    logic [6:0]  ebus_pi;
    logic [35:0] dev_out_data;
    logic        dev_out_valid, dev_out_ready;
    logic [35:0] dev_in_data;
    logic        dev_in_valid;

    ebus_dev_responder #(.DEV_NUM(DEV), .FUNC_W(3)) dut (
        .clk(clk), .RESET(RESET), .ebus_cs(ebus_cs), .ebus_func(ebus_func),
        .ebus_demand(ebus_demand), .ebus_data_in(ebus_data_in),
        .ebus_data_out(ebus_data_out), .ebus_data_oe(ebus_data_oe), .ebus_xfer(ebus_xfer),
        .ebus_pi(ebus_pi), .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid),
        .dev_out_ready(dev_out_ready), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit rnd_hw = 0;

    // Device status as the EBOX would see it through CONI.
    bit          m_err, m_done, m_busy, m_valid;
    logic [2:0]  m_pia;
    logic [35:0] m_obuf, m_ibuf;
    logic [6:0]  m_pi;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] status_word();
        logic [35:0] w;
        w = '0;
        w[5] = m_err;
        w[4] = m_done;
        w[3] = m_busy;
        w[2:0] = m_pia;
        return w;
    endfunction

    function automatic logic [6:0] pi_of(input bit e, input bit dn, input logic [2:0] p);
        if (p != 3'd0 && (e || dn)) return 7'b1000000 >> (int'(p) - 1);
        return 7'd0;
    endfunction

    // One clock edge; op is the function whose side effect lands on this edge, or -1.
    task automatic step(input int op, input logic [35:0] d);
        bit rst, iv, rdy, o_done, o_busy, hs;
        logic [35:0] idat;
        if (rnd_hw) begin
            dev_in_valid  = ($urandom_range(0, 3) == 0);
            dev_in_data   = 36'({$urandom(), $urandom()});
            dev_out_ready = 1'($urandom_range(0, 1));
        end
        rst = RESET; iv = dev_in_valid; idat = dev_in_data; rdy = dev_out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_err = 0; m_done = 0; m_busy = 0; m_valid = 0;
            m_pia = '0; m_obuf = '0; m_ibuf = '0; m_pi = '0;
        end else begin
            m_pi = pi_of(m_err, m_done, m_pia);
            o_done = m_done; o_busy = m_busy;
            hs = m_valid && rdy;
            if (op == 0) begin
                if (d[5]) m_err = 0;
                if (d[4]) m_done = 0;
                m_pia = d[2:0];
            end
            if (op == 3) m_done = 0;
            if (hs) begin m_busy = 0; m_valid = 0; end
            if (op == 2) begin
                if (o_busy) m_err = 1;
                m_obuf = d; m_busy = 1; m_valid = 1;
            end
            if (iv) begin
                m_ibuf = idat;
                if (o_done) m_err = 1;
            end
            if ((op == 0 && d[3]) || hs || iv) m_done = 1;
        end
        chk("pi", ebus_pi, m_pi);
        chk("out_vld", dev_out_valid, m_valid);
        chk("out_dat", dev_out_data, m_obuf);
    endtask

    task automatic txn(input int f, input logic [35:0] d, input int hold, input bit drop, input bit in_at_se);
        logic [35:0] rd;
        bit is_rd;
        ebus_cs = DEV; ebus_func = 3'(f); ebus_data_in = d; ebus_demand = 1;
        step(-1, '0);
        chk("act_xfer", ebus_xfer, 0);
        chk("act_oe", ebus_data_oe, 0);
        is_rd = (f == 1) || (f == 3);
        rd = (f == 1) ? status_word() : ((f == 3) ? m_ibuf : '0);
        if (drop) ebus_demand = 0;
        if (in_at_se) begin dev_in_valid = 1; dev_in_data = 36'o4242; end
        step(f, d);
        if (in_at_se) dev_in_valid = 0;
        if (!drop) begin
            for (int i = 0; i <= hold; i++) begin
                if (i > 0) step(-1, '0);
                chk("xfer", ebus_xfer, 1);
                chk("oe", ebus_data_oe, is_rd);
                chk("rdata", ebus_data_out, is_rd ? rd : 36'd0);
            end
            ebus_demand = 0;
            step(-1, '0);
        end
        chk("drop_xfer", ebus_xfer, 0);
        chk("drop_oe", ebus_data_oe, 0);
        chk("drop_dout", ebus_data_out, 0);
        step(-1, '0);
        chk("idle_xfer", ebus_xfer, 0);
    endtask

    task automatic ign(input logic [6:0] cs, input int f);
        ebus_cs = cs; ebus_func = 3'(f); ebus_data_in = 36'o777777; ebus_demand = 1;
        for (int i = 0; i < 3; i++) begin
            step(-1, '0);
            chk("ign_xfer", ebus_xfer, 0);
            chk("ign_oe", ebus_data_oe, 0);
        end
        ebus_demand = 0;
        step(-1, '0);
    endtask

    initial begin
        RESET = 1; ebus_cs = '0; ebus_func = '0; ebus_demand = 0; ebus_data_in = '0;
        dev_out_ready = 0; dev_in_data = '0; dev_in_valid = 0;
        step(-1, '0);
        step(-1, '0);
        chk("rst_xfer", ebus_xfer, 0);
        chk("rst_oe", ebus_data_oe, 0);
        chk("rst_dout", ebus_data_out, 0);
        RESET = 0;
        step(-1, '0);

        // CONO: set DONE, PIA=5 -> level-5 request one clock after the status change
        txn(0, 36'o15, 2, 0, 0);
        chk("pi_lvl5", ebus_pi, 7'b0000100);
        txn(0, 36'o20, 0, 0, 0);
        txn(2, 36'o123456701234, 0, 0, 0);
        chk("obuf", dev_out_data, 36'o123456701234);
        dev_out_ready = 1;
        step(-1, '0);
        dev_out_ready = 0;
        chk("hs_vld", dev_out_valid, 0);
        txn(1, '0, 1, 0, 0);

        // Input overrun, DATAI read-back, ERR clear
        dev_in_valid = 1; dev_in_data = 36'o777;
        step(-1, '0);
        dev_in_data = 36'o555;
        step(-1, '0);
        dev_in_valid = 0;
        txn(1, '0, 0, 0, 0);
        txn(3, '0, 1, 0, 0);
        txn(0, 36'o40, 0, 0, 0);
        txn(1, '0, 0, 0, 0);

        ign(7'o5, 0);
        ign(DEV, 5);
        ign(DEV, 7);

        // Input strobe on the DATAI side-effect edge
        txn(3, '0, 0, 0, 1);
        txn(1, '0, 0, 0, 0);

        // Demand falls in ACT
        txn(2, 36'o1234, 0, 1, 0);
        dev_out_ready = 1;
        step(-1, '0);
        dev_out_ready = 0;

        // Reset during ACT of a DATAO, with demand still high afterwards
        ebus_cs = DEV; ebus_func = 3'd2; ebus_data_in = 36'o666; ebus_demand = 1;
        step(-1, '0);
        RESET = 1;
        step(-1, '0);
        RESET = 0;
        for (int i = 0; i < 3; i++) begin
            step(-1, '0);
            chk("post_rst_xfer", ebus_xfer, 0);
        end
        ebus_demand = 0;
        step(-1, '0);
        txn(1, '0, 0, 0, 0);

        rnd_hw = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0)
                ign(($urandom_range(0, 1) == 0) ? 7'o5 : DEV, int'($urandom_range(4, 7)));
            else
                txn(int'($urandom_range(0, 3)), 36'({$urandom(), $urandom()}),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 0);
        end
        rnd_hw = 0;
        dev_in_valid = 0;
        dev_out_ready = 0;
        txn(1, '0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
